// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// External-interrupt sequencer for the pipelined MIPS core.
//
// The asynchronous interrupter pin is synchronised and its rising edges are
// latched as a sticky pending request. The request is armed when interrupts
// are enabled and the core is not in debug stepping. It is then taken at the
// next real, non-ERET retirement in WB. Taking it saves the return PC in epc,
// clears IE, and issues a one-cycle flush/redirect to HANDLER_ADDR. An ERET
// retiring while in the handler sets IE again and redirects fetch back to epc.
//
// Ports:
//   clk          core clock
//   rst          asynchronous active-high reset
//   interrupter  external request pin (async), rising edge = request
//   debug_en     debug/step mode, blocks taking interrupts
//   ie_wr        IE write strobe (mtc0 Status in WB)
//   ie_wdata     new IE value
//   wb_valid     real instruction retiring in WB
//   wb_eret      retiring instruction is ERET
//   wb_next_pc   PC of the instruction after the retiring one
//   flush        one-cycle pulse, kill IF/ID/EX/MEM
//   redirect     one-cycle pulse with flush, load PC from redirect_pc
//   redirect_pc  redirect target, valid while redirect=1
//   epc          saved return address
//   ie           interrupt-enable bit
//   int_pending  latched request not yet serviced
//   in_handler   high while the handler is running
// -----------------------------------------------------------------------------
module int_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupter,
    input  logic        debug_en,
    input  logic        ie_wr,
    input  logic        ie_wdata,
    input  logic        wb_valid,
    input  logic        wb_eret,
    input  logic [31:0] wb_next_pc,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic        ie,
    output logic        int_pending,
    output logic        in_handler
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t state;

    logic sync_s1;
    logic sync_s2;
    logic sync_s3;
    logic pin_rise;
    logic arm_abort;
    logic take;
    logic eret_take;

    // Two-flop synchroniser for the async pin, plus a third flop so a level
    // held high yields a single rising-edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1 <= 1'b0;
            sync_s2 <= 1'b0;
            sync_s3 <= 1'b0;
        end else begin
            sync_s1 <= interrupter;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
        end
    end

    assign pin_rise = sync_s2 & ~sync_s3;

    // While armed, debug mode or disabling IE drops back to IDLE; that check
    // wins over a retirement in the same cycle. ERET is never a take point.
    assign arm_abort = (state == ARM) && (debug_en || (ie_wr && !ie_wdata));
    assign take      = (state == ARM) && !arm_abort && wb_valid && !wb_eret;
    assign eret_take = (state == HANDLER) && wb_valid && wb_eret;

    // Sequencer state, IE/EPC bookkeeping and the registered redirect pulse.
    // A new edge in the take cycle keeps the request pending. IE is held low
    // for the whole handler so ie_wr cannot re-enable nesting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= 32'h0;
            epc         <= 32'h0;
            ie          <= 1'b1;
            int_pending <= 1'b0;
            in_handler  <= 1'b0;
        end else begin
            flush       <= take | eret_take;
            redirect    <= take | eret_take;
            int_pending <= pin_rise | (int_pending & ~take);

            if (take) begin
                redirect_pc <= HANDLER_ADDR;
                epc         <= wb_next_pc;
            end else if (eret_take) begin
                redirect_pc <= epc;
            end

            if (take) begin
                ie <= 1'b0;
            end else if (eret_take) begin
                ie <= 1'b1;
            end else if (state == HANDLER) begin
                ie <= 1'b0;
            end else if (ie_wr) begin
                ie <= ie_wdata;
            end

            case (state)
                IDLE: begin
                    if (int_pending && ie && !debug_en) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (arm_abort) begin
                        state <= IDLE;
                    end else if (take) begin
                        state      <= HANDLER;
                        in_handler <= 1'b1;
                    end
                end
                HANDLER: begin
                    if (eret_take) begin
                        state      <= IDLE;
                        in_handler <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_handler <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
// Self-checking bench for int_ctrl: directed scenarios (reset, basic take,
// ERET return, masking, debug hold, back-to-back, async reset) followed by a
// randomized run compared cycle by cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

    localparam logic [31:0] HADDR = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rst;
    logic        interrupter;
    logic        debug_en;
    logic        ie_wr;
    logic        ie_wdata;
    logic        wb_valid;
    logic        wb_eret;
    logic [31:0] wb_next_pc;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] epc;
    logic        ie;
    logic        int_pending;
    logic        in_handler;

    int total = 0;
    int bad   = 0;

    int_ctrl #(.HANDLER_ADDR(HADDR)) dut (
        .clk        (clk),
        .rst        (rst),
        .interrupter(interrupter),
        .debug_en   (debug_en),
        .ie_wr      (ie_wr),
        .ie_wdata   (ie_wdata),
        .wb_valid   (wb_valid),
        .wb_eret    (wb_eret),
        .wb_next_pc (wb_next_pc),
        .flush      (flush),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .epc        (epc),
        .ie         (ie),
        .int_pending(int_pending),
        .in_handler (in_handler)
    );

    always #5 clk = ~clk;

    // Outputs are looked at 1ns after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Stimulus only: retire an ERET to leave the handler.
    task automatic do_eret();
        wb_valid = 1'b1;
        wb_eret  = 1'b1;
        tick();
        wb_eret  = 1'b0;
        wb_valid = 1'b0;
        tick();
    endtask

    task automatic full_reset();
        rst = 1'b1; interrupter = 1'b0; debug_en = 1'b0; ie_wr = 1'b0;
        ie_wdata = 1'b0; wb_valid = 1'b0; wb_eret = 1'b0; wb_next_pc = 32'h0;
        settle(2);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        full_reset();
        total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush: got %b want 0", flush); end
        total++; if (redirect !== 1'b0) begin bad++; $display("[TB] FAIL reset_redirect: got %b want 0", redirect); end
        total++; if (redirect_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_rpc: got %h want 0", redirect_pc); end
        total++; if (epc !== 32'h0) begin bad++; $display("[TB] FAIL reset_epc: got %h want 0", epc); end
        total++; if (ie !== 1'b1) begin bad++; $display("[TB] FAIL reset_ie: got %b want 1", ie); end
        total++; if (int_pending !== 1'b0) begin bad++; $display("[TB] FAIL reset_pending: got %b want 0", int_pending); end
        total++; if (in_handler !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_handler: got %b want 0", in_handler); end
    endtask

    task automatic test_basic_take();
        interrupter = 1'b1; wb_valid = 1'b1; wb_next_pc = 32'h0000_0104;
        tick(); // edge k
        tick(); // edge k+1
        total++; if (int_pending !== 1'b0) begin bad++; $display("[TB] FAIL take_pending_early: got %b want 0", int_pending); end
        tick(); // edge k+2
        total++; if (int_pending !== 1'b1) begin bad++; $display("[TB] FAIL take_pending_k2: got %b want 1", int_pending); end
        tick(); // edge k+3, armed
        total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL take_flush_early: got %b want 0", flush); end
        tick(); // edge k+4, take registered
        total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL take_flush: got %b want 1", flush); end
        total++; if (redirect !== 1'b1) begin bad++; $display("[TB] FAIL take_redirect: got %b want 1", redirect); end
        total++; if (redirect_pc !== HADDR) begin bad++; $display("[TB] FAIL take_rpc: got %h want %h", redirect_pc, HADDR); end
        total++; if (epc !== 32'h104) begin bad++; $display("[TB] FAIL take_epc: got %h want 104", epc); end
        total++; if (ie !== 1'b0) begin bad++; $display("[TB] FAIL take_ie: got %b want 0", ie); end
        total++; if (in_handler !== 1'b1) begin bad++; $display("[TB] FAIL take_in_handler: got %b want 1", in_handler); end
        total++; if (int_pending !== 1'b0) begin bad++; $display("[TB] FAIL take_pending_clr: got %b want 0", int_pending); end
        tick();
        total++; if (flush !== 1'b0 || redirect !== 1'b0) begin bad++; $display("[TB] FAIL take_pulse_width: got flush=%b redirect=%b want 0 0", flush, redirect); end
        // interrupter stays high through the handler: no second request
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (flush !== 1'b0 || int_pending !== 1'b0 || in_handler !== 1'b1) begin
                bad++; $display("[TB] FAIL held_level: got flush=%b pend=%b inh=%b want 0 0 1", flush, int_pending, in_handler);
            end
        end
    endtask

    task automatic test_eret_return();
        ie_wr = 1'b1; ie_wdata = 1'b1;   // ignored inside the handler
        tick();
        ie_wr = 1'b0;
        total++; if (ie !== 1'b0) begin bad++; $display("[TB] FAIL handler_ie_wr: got %b want 0", ie); end
        wb_valid = 1'b1; wb_eret = 1'b1;
        tick();
        total++; if (flush !== 1'b1 || redirect !== 1'b1) begin bad++; $display("[TB] FAIL eret_pulse: got flush=%b redirect=%b want 1 1", flush, redirect); end
        total++; if (redirect_pc !== 32'h104) begin bad++; $display("[TB] FAIL eret_rpc: got %h want 104", redirect_pc); end
        total++; if (ie !== 1'b1) begin bad++; $display("[TB] FAIL eret_ie: got %b want 1", ie); end
        total++; if (in_handler !== 1'b0) begin bad++; $display("[TB] FAIL eret_in_handler: got %b want 0", in_handler); end
        // ERET outside the handler is ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (flush !== 1'b0 || ie !== 1'b1 || int_pending !== 1'b0) begin
                bad++; $display("[TB] FAIL eret_outside: got flush=%b ie=%b pend=%b want 0 1 0", flush, ie, int_pending);
            end
        end
        wb_eret = 1'b0; wb_valid = 1'b0; interrupter = 1'b0;
        settle(4);
    endtask

    task automatic test_masking();
        int seen;
        ie_wr = 1'b1; ie_wdata = 1'b0;
        tick();
        ie_wr = 1'b0;
        total++; if (ie !== 1'b0) begin bad++; $display("[TB] FAIL mask_ie: got %b want 0", ie); end
        interrupter = 1'b1; wb_valid = 1'b1; wb_next_pc = 32'h0000_0400;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL mask_no_flush: got %b want 0", flush); end
        end
        total++; if (int_pending !== 1'b1) begin bad++; $display("[TB] FAIL mask_pending: got %b want 1", int_pending); end
        ie_wr = 1'b1; ie_wdata = 1'b1;
        tick();
        ie_wr = 1'b0;
        total++; if (ie !== 1'b1) begin bad++; $display("[TB] FAIL unmask_ie: got %b want 1", ie); end
        seen = 0;
        for (int i = 0; i < 5 && seen == 0; i++) begin
            tick();
            if (flush === 1'b1) seen = 1;
        end
        total++; if (seen != 1) begin bad++; $display("[TB] FAIL unmask_take: got no flush want flush within 5 cycles"); end
        total++; if (redirect_pc !== HADDR || epc !== 32'h400) begin bad++; $display("[TB] FAIL unmask_target: got rpc=%h epc=%h want %h 400", redirect_pc, epc, HADDR); end
        do_eret();
        interrupter = 1'b0;
        settle(4);
    endtask

    task automatic test_debug_hold();
        int seen;
        debug_en = 1'b1; wb_valid = 1'b1; wb_next_pc = 32'h0000_0500; interrupter = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL debug_no_flush: got %b want 0", flush); end
        end
        total++; if (int_pending !== 1'b1) begin bad++; $display("[TB] FAIL debug_pending: got %b want 1", int_pending); end
        debug_en = 1'b0; wb_valid = 1'b0;
        settle(2);
        total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL debug_idle_flush: got %b want 0", flush); end
        wb_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 && seen == 0; i++) begin
            tick();
            if (flush === 1'b1) seen = 1;
        end
        total++; if (seen != 1) begin bad++; $display("[TB] FAIL debug_release_take: got no flush want flush within 2 cycles"); end
        total++; if (epc !== 32'h500) begin bad++; $display("[TB] FAIL debug_epc: got %h want 500", epc); end
        do_eret();
        interrupter = 1'b0;
        settle(4);
    endtask

    task automatic test_back_to_back();
        int seen;
        interrupter = 1'b1; wb_valid = 1'b1; wb_next_pc = 32'h0000_0200;
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            tick();
            if (flush === 1'b1) seen = 1;
        end
        total++; if (seen != 1 || epc !== 32'h200) begin bad++; $display("[TB] FAIL b2b_first_take: got seen=%0d epc=%h want 1 200", seen, epc); end
        interrupter = 1'b0;
        settle(3);
        interrupter = 1'b1;
        settle(4);
        total++; if (int_pending !== 1'b1 || in_handler !== 1'b1 || flush !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_nested_pending: got pend=%b inh=%b flush=%b want 1 1 0", int_pending, in_handler, flush);
        end
        wb_eret = 1'b1;
        tick();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h200 || ie !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_eret: got flush=%b rpc=%h ie=%b want 1 200 1", flush, redirect_pc, ie);
        end
        wb_eret = 1'b0; wb_next_pc = 32'h0000_0300;
        tick();
        total++; if (flush !== 1'b0 || in_handler !== 1'b0) begin bad++; $display("[TB] FAIL b2b_arm: got flush=%b inh=%b want 0 0", flush, in_handler); end
        tick();
        total++; if (flush !== 1'b1 || redirect_pc !== HADDR || epc !== 32'h300 || int_pending !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_second_take: got flush=%b rpc=%h epc=%h pend=%b want 1 %h 300 0", flush, redirect_pc, epc, int_pending, HADDR);
        end
        do_eret();
        interrupter = 1'b0;
        settle(4);
    endtask

    task automatic test_async_reset();
        // reset while armed
        wb_valid = 1'b0; interrupter = 1'b1;
        settle(4);
        #2 rst = 1'b1;
        #1;
        total++; if (int_pending !== 1'b0 || ie !== 1'b1 || epc !== 32'h0 || redirect_pc !== 32'h0 || in_handler !== 1'b0 || flush !== 1'b0) begin
            bad++; $display("[TB] FAIL arst_arm: got pend=%b ie=%b epc=%h rpc=%h inh=%b flush=%b want 0 1 0 0 0 0", int_pending, ie, epc, redirect_pc, in_handler, flush);
        end
        interrupter = 1'b0;
        settle(2);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (int_pending !== 1'b0 || flush !== 1'b0) begin bad++; $display("[TB] FAIL arst_dropped: got pend=%b flush=%b want 0 0", int_pending, flush); end
        end
        // reset right after a take is registered: the pulse is cancelled
        interrupter = 1'b1;
        settle(4);
        wb_valid = 1'b1; wb_next_pc = 32'h0000_0600;
        tick();
        total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL arst_take_setup: got %b want 1", flush); end
        #2 rst = 1'b1;
        #1;
        total++; if (flush !== 1'b0 || redirect !== 1'b0 || epc !== 32'h0 || ie !== 1'b1 || in_handler !== 1'b0 || int_pending !== 1'b0) begin
            bad++; $display("[TB] FAIL arst_take: got flush=%b redir=%b epc=%h ie=%b inh=%b pend=%b want 0 0 0 1 0 0", flush, redirect, epc, ie, in_handler, int_pending);
        end
        interrupter = 1'b0; wb_valid = 1'b0;
        settle(2);
        rst = 1'b0;
        tick();
        total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL arst_after: got %b want 0", flush); end
    endtask

    // Randomized run against a behavioural model built straight from the
    // interrupt rules: pin samples kept as a short history, the request and
    // handler status as plain flags.
    task automatic test_random();
        logic [2:0]  pin_hist;
        logic        m_pending, m_ie, m_waiting, m_servicing, m_pulse;
        logic [31:0] m_epc, m_target;
        logic        rose, can_take, is_take, is_ret, abort_arm;
        full_reset();
        pin_hist = 3'b000; m_pending = 0; m_ie = 1; m_waiting = 0; m_servicing = 0;
        m_pulse = 0; m_epc = 0; m_target = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 5) == 0) interrupter = ~interrupter;
            if ($urandom_range(0, 29) == 0) debug_en = ~debug_en;
            ie_wr    = ($urandom_range(0, 14) == 0);
            ie_wdata = $urandom_range(0, 1);
            wb_valid = ($urandom_range(0, 9) < 6);
            wb_eret  = ($urandom_range(0, 3) == 0);
            wb_next_pc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};

            rose      = pin_hist[1] && !pin_hist[2];
            abort_arm = m_waiting && (debug_en || (ie_wr && !ie_wdata));
            can_take  = m_waiting && !abort_arm;
            is_take   = can_take && wb_valid && !wb_eret;
            is_ret    = m_servicing && wb_valid && wb_eret;

            m_pulse = is_take || is_ret;
            if (is_take) m_target = HADDR;
            else if (is_ret) m_target = m_epc;
            if (is_take) m_epc = wb_next_pc;

            if (is_take) m_ie = 0;
            else if (is_ret) m_ie = 1;
            else if (!m_servicing && ie_wr) m_ie = ie_wdata;

            if (is_take) begin
                m_waiting = 0; m_servicing = 1;
            end else if (is_ret) begin
                m_servicing = 0;
            end else if (abort_arm) begin
                m_waiting = 0;
            end else if (!m_waiting && !m_servicing && m_pending && (ie === 1'b1 ? 1'b1 : 1'b0) == 1'b1 && !debug_en) begin
                m_waiting = 1;
            end
            m_pending = rose || (m_pending && !is_take);
            pin_hist  = {pin_hist[1:0], interrupter};

            tick();
            total++; if (flush !== m_pulse) begin bad++; $display("[TB] FAIL rnd_flush c%0d: got %b want %b", cyc, flush, m_pulse); end
            total++; if (redirect !== m_pulse) begin bad++; $display("[TB] FAIL rnd_redirect c%0d: got %b want %b", cyc, redirect, m_pulse); end
            if (m_pulse) begin
                total++; if (redirect_pc !== m_target) begin bad++; $display("[TB] FAIL rnd_rpc c%0d: got %h want %h", cyc, redirect_pc, m_target); end
            end
            total++; if (epc !== m_epc) begin bad++; $display("[TB] FAIL rnd_epc c%0d: got %h want %h", cyc, epc, m_epc); end
            total++; if (ie !== m_ie) begin bad++; $display("[TB] FAIL rnd_ie c%0d: got %b want %b", cyc, ie, m_ie); end
            total++; if (int_pending !== m_pending) begin bad++; $display("[TB] FAIL rnd_pending c%0d: got %b want %b", cyc, int_pending, m_pending); end
            total++; if (in_handler !== m_servicing) begin bad++; $display("[TB] FAIL rnd_in_handler c%0d: got %b want %b", cyc, in_handler, m_servicing); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_take();
        test_eret_return();
        test_masking();
        test_debug_hold();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the bench ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

External-interrupt sequencer for the pipelined MIPS core. It synchronises the `interrupter` pin and latches its rising edges as a pending request. It waits for a precise retirement point in WB, then flushes the pipeline and redirects fetch to the handler, saving the return PC in EPC. On ERET it restores fetch to EPC and re-enables interrupts; it holds requests off while the core is in debug stepping.

## Interface
Parameters:
- HANDLER_ADDR, 32'h0000_0020, fetch address of the interrupt handler
- 

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- interrupter  in  1  external interrupt request, asynchronous to clk; a rising edge is a request
- debug_en  in  1  core in debug/step mode; no interrupt is taken while high
- ie_wr  in  1  write strobe for the interrupt-enable bit (mtc0 Status in WB)
- ie_wdata  in  1  new IE value
- wb_valid  in  1  a real instruction retires in WB this cycle
- wb_eret  in  1  the retiring instruction is ERET (qualified by wb_valid)
- wb_next_pc  in  32  address of the instruction that would execute after the retiring one
- flush  out  1  one-cycle pulse; kill IF/ID/EX/MEM
- redirect  out  1  one-cycle pulse, coincident with flush; load PC from redirect_pc
- redirect_pc  out  32  target PC, valid while redirect=1
- epc  out  32  saved return address
- ie  out  1  interrupt-enable bit
- int_pending  out  1  latched request not yet serviced
- in_handler  out  1  high while state=HANDLER

## Operation
- Reset values:
  - ie=1
  - epc=0
  - flush=0, redirect=0, redirect_pc=0
  - int_pending=0
  - in_handler=0
  - synchroniser flops=0
  - state=IDLE
- Synchroniser: two flops (s1, s2) plus a third flop s3 for edge detect; edge = s2 & ~s3.
- Pending handling:
  - An edge sets int_pending, which is sticky.
  - Taking the interrupt clears int_pending.
  - An edge in the same cycle as the clear wins: int_pending stays 1.
- A level held high produces exactly one request; the pin must fall and rise again for the next one.
- FSM:
  - IDLE: if int_pending & ie & ~debug_en, go to ARM.
  - ARM:
    - If debug_en=1, or ie_wr with ie_wdata=0, go to IDLE (request stays pending).
    - Otherwise, on wb_valid & ~wb_eret (take):
      - capture epc ← wb_next_pc, clear int_pending, ie ← 0;
      - next cycle flush=redirect=1 and redirect_pc=HANDLER_ADDR;
      - go to HANDLER.
    - wb_valid & wb_eret in ARM is not a take point; keep waiting.
  - HANDLER:
    - ie is forced 0 and ie_wr is ignored (no nesting).
    - Edges still set int_pending.
    - On wb_valid & wb_eret: ie ← 1; next cycle flush=redirect=1 and redirect_pc=epc; go to IDLE.
- Outside HANDLER:
  - ERET is ignored: no redirect, ie unchanged.
  - ie_wr updates ie normally.
- Precedence within one cycle: rst > take/ERET > ie_wr.
- A pending request taken right after ERET is a legal back-to-back sequence:
  - IDLE sees int_pending & ie=1 the cycle after ERET.

## Timing
- All outputs are registered. flush and redirect are high for exactly one cycle.
- Request latency:
  - interrupter rises before edge k;
  - int_pending=1 after edge k+2;
  - ARM after edge k+3 (if ie=1 and debug_en=0).
- Take latency: wb_valid sampled in ARM at edge t; flush/redirect high during cycle t..t+1; epc valid after edge t.
- ERET latency: wb_valid & wb_eret sampled at edge t; redirect to epc high during cycle t..t+1; ie=1 after edge t.
- Reset mid-operation (any state) returns everything to reset values immediately and drops pending requests. A flush/redirect pulse in flight is cancelled.

## Test plan
- Basic take:
  - Reset, then interrupter rises.
  - Drive wb_valid=1, wb_next_pc=32'h0000_0104 continuously.
  - Required: int_pending after 3 edges, one flush+redirect pulse with redirect_pc=32'h20, epc=32'h104, ie=0, in_handler=1.
- ERET return: from HANDLER, present wb_valid=1, wb_eret=1 → one pulse with redirect_pc=32'h104, ie=1, in_handler=0.
- Masking: ie_wr=1, ie_wdata=0, then raise interrupter → int_pending=1, no flush. Then ie_wr=1, ie_wdata=1 → take occurs with handler redirect.
- Debug hold: debug_en=1 when the edge arrives → no take for 20 cycles, int_pending stays 1. Drop debug_en → take within 2 cycles of the next wb_valid.
- Nested/held level:
  - Keep interrupter high through the handler → exactly one take.
  - A second rising edge during HANDLER sets int_pending; after ERET it is taken back-to-back with epc updated.
- Async reset: assert rst in ARM and in the cycle a take is registered → all outputs return to reset values at once, with no flush pulse.
